// File: rtl/olp_pkg.sv
// Shared state encoding, size/verdict codes and map geometry for the OLP dispatcher.
package olp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DISPATCH,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int POS_W      = 13;
  localparam int SIZE_W     = 2;
  localparam int FACE_POS_W = 21;

  localparam logic [SIZE_W-1:0] SIZE_S0 = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_S1 = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_S2 = 2'd2;

  localparam logic [1:0] PASS_ACC = 2'b11;
  localparam logic [1:0] PASS_REJ = 2'b10;

  localparam int MAP_W    = 80;
  localparam int MAP_H    = 60;
  localparam int MAP_BITS = MAP_W * MAP_H;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic [POS_W-1:0]  pos;
  } cand_t;

  function automatic logic size_valid(input logic [SIZE_W-1:0] size);
    return size <= SIZE_S2;
  endfunction

endpackage

// File: rtl/olp_cand_fifo.sv
// Show-ahead synchronous FIFO: head_dat is valid whenever empty is low, zero-latency read.
// Pushes are dropped while full and pops ignored while empty; push+pop together keeps occupancy.
module olp_cand_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 8
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && !empty;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/olp_dispatcher.sv
// Clears the occupancy map per frame, then issues buffered candidates to the checker one at a time.
// oRun/oFace_Valid registered; dispatch stalls while a face awaits iFace_Ready, oCand_Ready drops when full.
module olp_dispatcher
  import olp_pkg::*;
#(
  parameter int CAND_DEPTH   = 8,
  parameter int MAX_FACES    = 16,
  parameter int CLEAR_CYCLES = 4802,
  parameter int TIMEOUT      = 4096
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iFrame_Start,
  input  logic                  iFrame_End,
  input  logic                  iCand_Valid,
  output logic                  oCand_Ready,
  input  logic [POS_W-1:0]      iCand_Position,
  input  logic [SIZE_W-1:0]     iCand_Size,
  output logic                  oRun,
  output logic                  oSet,
  output logic [POS_W-1:0]      oPosition,
  output logic [SIZE_W-1:0]     oSize,
  input  logic [1:0]            iPass,
  input  logic                  iFinish,
  input  logic [FACE_POS_W-1:0] iFace_Pos,
  input  logic [SIZE_W-1:0]     iFace_Size,
  output logic                  oFace_Valid,
  input  logic                  iFace_Ready,
  output logic [FACE_POS_W-1:0] oFace_Pos,
  output logic [SIZE_W-1:0]     oFace_Size,
  output logic                  oFrame_Done,
  output logic [4:0]            oFace_Count,
  output logic                  oError
);
  localparam int CNT_MAX = (CLEAR_CYCLES > TIMEOUT) ? CLEAR_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD   = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]       FACE_LIMIT = 5'(MAX_FACES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             end_flag;
  logic             accepting;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  cand_t            cand_in;
  cand_t            head;

  assign accepting   = (state == ST_CLEAR) || (state == ST_DISPATCH) || (state == ST_WAIT);
  assign oCand_Ready = accepting && !fifo_full;
  assign cand_in     = '{size: iCand_Size, pos: iCand_Position};

  // The head leaves unless it is a legal issue held back by a pending result.
  assign fifo_pop = (state == ST_DISPATCH) && !fifo_empty &&
                    (!size_valid(head.size) || (oFace_Count >= FACE_LIMIT) || !oFace_Valid);

  olp_cand_fifo #(
    .WIDTH ($bits(cand_t)),
    .DEPTH (CAND_DEPTH)
  ) u_cand_fifo (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .push_vld (iCand_Valid && oCand_Ready),
    .push_dat (cand_in),
    .pop_rdy  (fifo_pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      end_flag    <= 1'b0;
      oRun        <= 1'b0;
      oSet        <= 1'b0;
      oPosition   <= '0;
      oSize       <= '0;
      oFace_Valid <= 1'b0;
      oFace_Pos   <= '0;
      oFace_Size  <= '0;
      oFrame_Done <= 1'b0;
      oFace_Count <= '0;
      oError      <= 1'b0;
    end else begin
      oRun        <= 1'b0;
      oSet        <= 1'b0;
      oFrame_Done <= 1'b0;
      if (oFace_Valid && iFace_Ready) oFace_Valid <= 1'b0;
      if (accepting && iFrame_End) end_flag <= 1'b1;
      if (iFrame_Start && (state != ST_IDLE)) oError <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (iFrame_Start) begin
            oSet        <= 1'b1;
            cnt         <= CLEAR_LOAD;
            oFace_Count <= '0;
            end_flag    <= 1'b0;
            oError      <= 1'b0;
            state       <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (cnt == '0) state <= ST_DISPATCH;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DISPATCH: begin
          if (fifo_empty) begin
            if (end_flag) begin
              oFrame_Done <= 1'b1;
              state       <= ST_DONE;
            end
          end else if (!size_valid(head.size)) begin
            oError <= 1'b1;
          end else if ((oFace_Count < FACE_LIMIT) && !oFace_Valid) begin
            oPosition <= head.pos;
            oSize     <= head.size;
            oRun      <= 1'b1;
            cnt       <= TMO_LOAD;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (iPass == PASS_ACC) begin
            oFace_Pos   <= iFace_Pos;
            oFace_Size  <= iFace_Size;
            oFace_Valid <= 1'b1;
            if (oFace_Count < FACE_LIMIT) oFace_Count <= oFace_Count + 5'd1;
          end
          if (iFinish) begin
            state <= ST_DISPATCH;
          end else if (cnt == '0) begin
            oError <= 1'b1;
            state  <= ST_DISPATCH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_olp_dispatcher.sv
// Scoreboard bench: frame-level reference model feeds expectation queues, monitors pop and compare.
module tb_olp_dispatcher;
  import olp_pkg::*;

  localparam int CLEAR_CYCLES = 4802;
  localparam int TIMEOUT      = 4096;
  localparam int MAX_FACES    = 16;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iFrame_Start = 1'b0;
  logic        iFrame_End = 1'b0;
  logic        iCand_Valid = 1'b0;
  logic        oCand_Ready;
  logic [12:0] iCand_Position = '0;
  logic [1:0]  iCand_Size = '0;
  logic        oRun;
  logic        oSet;
  logic [12:0] oPosition;
  logic [1:0]  oSize;
  logic [1:0]  iPass = '0;
  logic        iFinish = 1'b0;
  logic [20:0] iFace_Pos = '0;
  logic [1:0]  iFace_Size = '0;
  logic        oFace_Valid;
  logic        iFace_Ready = 1'b0;
  logic [20:0] oFace_Pos;
  logic [1:0]  oFace_Size;
  logic        oFrame_Done;
  logic [4:0]  oFace_Count;
  logic        oError;

  always #5 iClk = ~iClk;

  olp_dispatcher dut (
    .iClk(iClk), .iReset_n(iReset_n), .iFrame_Start(iFrame_Start), .iFrame_End(iFrame_End),
    .iCand_Valid(iCand_Valid), .oCand_Ready(oCand_Ready), .iCand_Position(iCand_Position),
    .iCand_Size(iCand_Size), .oRun(oRun), .oSet(oSet), .oPosition(oPosition), .oSize(oSize),
    .iPass(iPass), .iFinish(iFinish), .iFace_Pos(iFace_Pos), .iFace_Size(iFace_Size),
    .oFace_Valid(oFace_Valid), .iFace_Ready(iFace_Ready), .oFace_Pos(oFace_Pos),
    .oFace_Size(oFace_Size), .oFrame_Done(oFrame_Done), .oFace_Count(oFace_Count), .oError(oError)
  );

  // verdict 2'b00 means the checker never answers
  typedef struct { logic [1:0] verdict; int lat; logic [20:0] fpos; logic [1:0] fsize; } plan_t;
  typedef struct { logic [12:0] pos; logic [1:0] size; } iss_t;
  typedef struct { logic [20:0] pos; logic [1:0] size; } face_t;

  plan_t plan_q[$];
  iss_t  iss_q[$];
  face_t face_q[$];
  int    done_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int run_cnt = 0, face_cnt = 0, done_cnt = 0, set_cnt = 0, done_target = 0;
  int first_run_cyc = -1, last_set_cyc = -1, err_rise_cyc = -1;
  int acc_cnt = 0;
  bit exp_err = 1'b0;
  bit hold_ready = 1'b0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic plan_t mk(input logic [1:0] v, input int lat, input logic [20:0] fp, input logic [1:0] fs);
    plan_t p;
    p.verdict = v; p.lat = lat; p.fpos = fp; p.fsize = fs;
    return p;
  endfunction

  function automatic plan_t rand_plan(input logic [1:0] v);
    return mk(v, int'($urandom_range(1, 4)), 21'($urandom()), 2'($urandom_range(0, 2)));
  endfunction

  // Reference: candidates are handled strictly in arrival order within a frame.
  function automatic void model_cand(input logic [12:0] pos, input logic [1:0] size, input plan_t p);
    if (size == 2'd3) begin
      exp_err = 1'b1;
    end else if (acc_cnt < MAX_FACES) begin
      iss_q.push_back('{pos: pos, size: size});
      plan_q.push_back(p);
      if (p.verdict == 2'b00) exp_err = 1'b1;
      if (p.verdict == PASS_ACC) begin
        acc_cnt++;
        face_q.push_back('{pos: p.fpos, size: p.fsize});
      end
    end
  endfunction

  initial begin : monitor
    iss_t e;
    face_t f;
    forever begin
      @(negedge iClk);
      if (iReset_n) begin
        if (oRun) begin
          run_cnt++;
          if (first_run_cyc < 0) first_run_cyc = cyc;
          if (iss_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_run: pos %0d size %0d with nothing expected", oPosition, oSize);
          end else begin
            e = iss_q.pop_front();
            check("run_pos", oPosition, e.pos);
            check("run_size", oSize, e.size);
          end
        end
        if (oFace_Valid && iFace_Ready) begin
          face_cnt++;
          if (face_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_face: pos %0d size %0d", oFace_Pos, oFace_Size);
          end else begin
            f = face_q.pop_front();
            check("face_pos", oFace_Pos, f.pos);
            check("face_size", oFace_Size, f.size);
          end
        end
        if (oFrame_Done) begin
          done_cnt++;
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: count %0d", oFace_Count);
          end else begin
            check("frame_count", oFace_Count, done_q.pop_front());
          end
        end
        if (oSet) begin set_cnt++; last_set_cyc = cyc; end
        if (oError && err_rise_cyc < 0) err_rise_cyc = cyc;
      end
    end
  end

  initial begin : checker_model
    plan_t p;
    forever begin
      @(negedge iClk);
      if (iReset_n && oRun && plan_q.size() != 0) begin
        p = plan_q.pop_front();
        if (p.verdict != 2'b00) begin
          repeat (p.lat) @(posedge iClk);
          #1;
          iPass = p.verdict; iFace_Pos = p.fpos; iFace_Size = p.fsize;
          @(posedge iClk); #1;
          iPass = 2'b00; iFinish = 1'b1;
          @(posedge iClk); #1;
          iFinish = 1'b0;
        end
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge iClk); #1;
      iFace_Ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #1200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // All main-thread tasks start and end at posedge+#1.
  task automatic start_frame();
    acc_cnt = 0; exp_err = 1'b0; first_run_cyc = -1;
    iFrame_Start = 1'b1;
    @(posedge iClk); #1;
    iFrame_Start = 1'b0;
    check("set_pulse_hi", oSet, 1);
    @(posedge iClk); #1;
    check("set_pulse_lo", oSet, 0);
    check("err_cleared", oError, 0);
    err_rise_cyc = -1;
  endtask

  task automatic end_frame();
    iFrame_End = 1'b1;
    @(posedge iClk); #1;
    iFrame_End = 1'b0;
    done_q.push_back(acc_cnt);
    done_target++;
  endtask

  task automatic push(input logic [12:0] pos, input logic [1:0] size, input plan_t p, output int acc_cyc);
    int n = 0;
    iCand_Position = pos; iCand_Size = size; iCand_Valid = 1'b1;
    @(negedge iClk);
    while (!oCand_Ready && n < 20000) begin @(negedge iClk); n++; end
    acc_cyc = cyc;
    if (!oCand_Ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: oCand_Ready stayed 0 for pos %0d", pos);
    end else begin
      model_cand(pos, size, p);
    end
    @(posedge iClk); #1;
    iCand_Valid = 1'b0;
  endtask

  task automatic wait_runs(input int target);
    int n = 0;
    while (run_cnt < target && n < 20000) begin @(posedge iClk); #1; n++; end
    if (run_cnt < target) begin
      checks++; errors++;
      $display("FAIL run_timeout: runs %0d wanted %0d", run_cnt, target);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((done_cnt < done_target || oFace_Valid) && n < 30000) begin @(posedge iClk); #1; n++; end
    if (done_cnt < done_target || oFace_Valid) begin
      checks++; errors++;
      $display("FAIL done_timeout: frames done %0d wanted %0d", done_cnt, done_target);
    end
    check("err_at_done", oError, exp_err);
  endtask

  initial begin : main
    int a, r, f0, s, bad_idx;
    logic [1:0] sz;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_outputs", {oCand_Ready, oRun, oSet, oPosition, oSize, oFace_Valid, oFace_Pos,
                          oFace_Size, oFrame_Done, oFace_Count, oError}, 0);
    iReset_n = 1'b1;
    @(posedge iClk); #1;
    check("idle_outputs", {oCand_Ready, oRun, oSet, oFace_Valid, oFrame_Done, oFace_Count, oError}, 0);

    // single accepted candidate
    start_frame();
    push(13'd100, SIZE_S1, mk(PASS_ACC, 2, 21'd5000, SIZE_S1), a);
    end_frame();
    wait_done();
    check("t1_faces", face_cnt, 1);
    check("t1_clear_gap_ok", (first_run_cyc - last_set_cyc >= CLEAR_CYCLES) &&
                             (first_run_cyc - last_set_cyc <= CLEAR_CYCLES + 4), 1);

    // nine candidates against an 8-deep FIFO
    start_frame();
    r = run_cnt;
    for (int i = 0; i < 8; i++)
      push(13'(i * 7 + 1), 2'(i % 3), rand_plan($urandom_range(0, 1) ? PASS_ACC : PASS_REJ), a);
    @(negedge iClk);
    check("t2_ready_full", oCand_Ready, 0);
    @(posedge iClk); #1;
    push(13'd999, SIZE_S2, rand_plan(PASS_ACC), a);
    check("t2_ninth_after_pop", (first_run_cyc >= 0) && (a >= first_run_cyc), 1);
    end_frame();
    wait_done();
    check("t2_runs", run_cnt - r, 9);

    // mixed verdicts with the result sink stalled
    hold_ready = 1'b1;
    start_frame();
    f0 = face_cnt;
    push(13'd10, SIZE_S0, rand_plan(PASS_ACC), a);
    push(13'd20, SIZE_S1, rand_plan(PASS_REJ), a);
    push(13'd30, SIZE_S2, rand_plan(PASS_ACC), a);
    end_frame();
    s = 0;
    while (!oFace_Valid && s < 20000) begin @(posedge iClk); #1; s++; end
    r = run_cnt;
    repeat (20) @(posedge iClk);
    #1;
    check("t3_stall_runs", run_cnt - r, 0);
    check("t3_face_held", oFace_Valid, 1);
    hold_ready = 1'b0;
    wait_done();
    check("t3_faces", face_cnt - f0, 2);

    // face limit
    start_frame();
    f0 = face_cnt;
    for (int i = 0; i < 18; i++)
      push(13'($urandom_range(0, MAP_BITS - 1)), 2'($urandom_range(0, 2)), rand_plan(PASS_ACC), a);
    end_frame();
    wait_done();
    check("t4_faces", face_cnt - f0, MAX_FACES);

    // random frames, the second with one invalid size code
    for (int k = 0; k < 2; k++) begin
      start_frame();
      bad_idx = (k == 1) ? int'($urandom_range(0, 7)) : -1;
      for (int i = 0; i < 8; i++) begin
        sz = (i == bad_idx) ? 2'd3 : 2'($urandom_range(0, 2));
        push(13'($urandom_range(0, MAP_BITS - 1)), sz,
             rand_plan($urandom_range(0, 1) ? PASS_ACC : PASS_REJ), a);
      end
      end_frame();
      wait_done();
    end

    // checker never finishes: timeout then next candidate issued
    start_frame();
    r = run_cnt;
    push(13'd500, SIZE_S1, mk(2'b00, 1, '0, '0), a);
    push(13'd600, SIZE_S2, rand_plan(PASS_ACC), a);
    end_frame();
    wait_done();
    check("t6_tmo_delay", err_rise_cyc - first_run_cyc, TIMEOUT);
    check("t6_runs", run_cnt - r, 2);

    // frame start during WAIT
    start_frame();
    r = run_cnt;
    push(13'd42, SIZE_S1, mk(PASS_ACC, 30, 21'h1ABCD, SIZE_S2), a);
    end_frame();
    wait_runs(r + 1);
    repeat (3) @(posedge iClk);
    #1;
    s = set_cnt;
    iFrame_Start = 1'b1;
    @(posedge iClk); #1;
    iFrame_Start = 1'b0;
    exp_err = 1'b1;
    check("t7_err", oError, 1);
    @(posedge iClk); #1;
    check("t7_no_set", set_cnt - s, 0);
    wait_done();

    // asynchronous reset mid-WAIT
    start_frame();
    r = run_cnt;
    push(13'd7, SIZE_S0, mk(2'b00, 1, '0, '0), a);
    push(13'd8, SIZE_S1, rand_plan(PASS_ACC), a);
    wait_runs(r + 1);
    repeat (10) @(posedge iClk);
    #2;
    iReset_n = 1'b0;
    #1;
    check("t8_rst_outputs", {oCand_Ready, oRun, oSet, oPosition, oSize, oFace_Valid, oFace_Pos,
                             oFace_Size, oFrame_Done, oFace_Count, oError}, 0);
    iss_q.delete(); plan_q.delete(); face_q.delete();
    @(posedge iClk); #1;
    iReset_n = 1'b1;
    @(posedge iClk); #1;
    check("t8_idle_ready", oCand_Ready, 0);
    r = run_cnt;
    start_frame();
    end_frame();
    wait_done();
    check("t8_fifo_empty", run_cnt - r, 0);

    check("left_issues", iss_q.size(), 0);
    check("left_faces", face_q.size(), 0);
    check("left_dones", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
